// File: rtl/fabosc_clk_monitor.sv
// Fabric-oscillator frequency monitor and reset sequencer: counts synchronized MON_CLK
// edges per fixed window and releases fabric reset only while the count stays in range.
module fabosc_clk_monitor #(
  parameter int WINDOW_CYCLES = 5000,
  parameter int COUNT_LO      = 95,
  parameter int COUNT_HI      = 105,
  parameter int GOOD_WINDOWS  = 4,
  parameter int WARMUP_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MON_CLK,
  input  logic             ENABLE,
  input  logic             FAULT_CLR,
  output logic             CLK_OK,
  output logic             FAB_RESET_N,
  output logic             FAULT,
  output logic [CNT_W-1:0] LAST_COUNT,
  output logic [2:0]       STATE
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WARM = 3'd1;
  localparam logic [2:0] S_QUAL = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LO_V  = CNT_W'(COUNT_LO);
  localparam logic [CNT_W-1:0] CNT_HI_V  = CNT_W'(COUNT_HI);
  localparam logic [CNT_W-1:0] GOOD_N    = CNT_W'(GOOD_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] last_count_q, last_count_d;
  logic             fault_q, fault_d;
  logic             clk_ok_q, clk_ok_d;

  logic             mon_edge, win_last, warm_last, win_good, win_dead, fault_set;
  logic [CNT_W-1:0] cnt_total, good_inc;

  // MON_CLK is asynchronous: two-flop synchronizer plus a history flop for edge detect
  always_comb begin
    sync1_d  = MON_CLK;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    mon_edge = sync2_q & ~hist_q;
  end

  // Window arithmetic; cnt_total already includes an edge seen this cycle
  always_comb begin
    win_last  = (win_cnt_q == WIN_LAST);
    warm_last = (warm_cnt_q == WARM_LAST);
    cnt_total = (mon_edge && edge_cnt_q != CNT_MAX) ? edge_cnt_q + ONE : edge_cnt_q;
    win_good  = (cnt_total >= CNT_LO_V) && (cnt_total <= CNT_HI_V);
    win_dead  = (cnt_total == '0);
    good_inc  = good_cnt_q + ONE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WARM;
        S_WARM: if (warm_last) state_d = S_QUAL;
        S_QUAL: if (win_last && win_good && good_inc == GOOD_N) state_d = S_RUN;
        S_RUN:  if (win_last && !win_good) state_d = S_FLT;
        S_FLT:  state_d = S_QUAL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counters default to cleared; only the active phase keeps them moving
  always_comb begin
    warm_cnt_d   = '0;
    win_cnt_d    = '0;
    edge_cnt_d   = '0;
    good_cnt_d   = good_cnt_q;
    last_count_d = last_count_q;
    fault_set    = 1'b0;
    if (!ENABLE) begin
      good_cnt_d = '0;
    end else begin
      case (state_q)
        S_WARM: begin
          if (!warm_last) warm_cnt_d = warm_cnt_q + ONE;
        end
        S_QUAL, S_RUN: begin
          if (win_last) begin
            last_count_d = cnt_total;
            if (state_q == S_QUAL) begin
              fault_set  = win_dead;
              good_cnt_d = win_good ? good_inc : '0;
              if (win_good && good_inc == GOOD_N) good_cnt_d = '0;
            end else begin
              fault_set = !win_good;
            end
          end else begin
            win_cnt_d  = win_cnt_q + ONE;
            edge_cnt_d = cnt_total;
          end
        end
        default: good_cnt_d = '0;
      endcase
    end
  end

  // Output decode works on the next state so CLK_OK tracks STATE on the same edge
  always_comb begin
    clk_ok_d = (state_d == S_RUN);
    if (fault_set)      fault_d = 1'b1;
    else if (FAULT_CLR) fault_d = 1'b0;
    else                fault_d = fault_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      warm_cnt_q   <= '0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      good_cnt_q   <= '0;
      last_count_q <= '0;
      fault_q      <= 1'b0;
      clk_ok_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      warm_cnt_q   <= warm_cnt_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      good_cnt_q   <= good_cnt_d;
      last_count_q <= last_count_d;
      fault_q      <= fault_d;
      clk_ok_q     <= clk_ok_d;
    end
  end

  assign CLK_OK      = clk_ok_q;
  assign FAB_RESET_N = clk_ok_q;
  assign FAULT       = fault_q;
  assign LAST_COUNT  = last_count_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_fabosc_clk_monitor.sv
// Bench for fabosc_clk_monitor: edge-index/queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized oscillator/enable traffic.
module tb_fabosc_clk_monitor;
  localparam int WC = 40, LO = 9, HI = 11, G = 2, W = 16, CW = 8;

  logic          CLK = 1'b0;
  logic          RESET, MON_CLK, ENABLE, FAULT_CLR;
  logic          CLK_OK, FAB_RESET_N, FAULT;
  logic [CW-1:0] LAST_COUNT;
  logic [2:0]    STATE;

  int tests = 0;
  int fails = 0;

  fabosc_clk_monitor #(
    .WINDOW_CYCLES(WC), .COUNT_LO(LO), .COUNT_HI(HI),
    .GOOD_WINDOWS(G), .WARMUP_CYCLES(W), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MON_CLK(MON_CLK), .ENABLE(ENABLE), .FAULT_CLR(FAULT_CLR),
    .CLK_OK(CLK_OK), .FAB_RESET_N(FAB_RESET_N), .FAULT(FAULT),
    .LAST_COUNT(LAST_COUNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitored oscillator: period in CLK cycles, 0 = stopped low
  int mon_per = 4;
  int mon_ph  = 0;
  initial begin
    MON_CLK = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_per == 0) MON_CLK = 1'b0;
      else begin
        mon_ph  = (mon_ph + 1) % mon_per;
        MON_CLK = (mon_ph < mon_per / 2);
      end
    end
  end

  // Reference model: edges are recorded by clock index, windows are index ranges
  int  m_state = 0, m_fault = 0, m_last = 0, m_good = 0, m_n = 0, m_wbeg = 0;
  bit  m_samp[$];
  int  m_dets[$];
  bit  m_ready = 0;

  task automatic model_step();
    bit det, good, dead, set;
    int cnt;
    m_n++;
    if (RESET) begin
      m_state = 0; m_fault = 0; m_last = 0; m_good = 0;
      m_samp = {1'b0, 1'b0, 1'b0};
      m_dets.delete();
      m_ready = 1;
      return;
    end
    det = m_samp[1] && !m_samp[0];
    m_samp.push_back(MON_CLK);
    void'(m_samp.pop_front());
    set = 0;
    if (!ENABLE) begin
      m_state = 0; m_good = 0; m_dets.delete();
    end else begin
      case (m_state)
        0: begin m_state = 1; m_wbeg = m_n + 1; end
        1: if (m_n == m_wbeg + W - 1) begin
             m_state = 2; m_wbeg = m_n + 1; m_good = 0; m_dets.delete();
           end
        2, 3: begin
          if (det) m_dets.push_back(m_n);
          if (m_n == m_wbeg + WC - 1) begin
            cnt    = (m_dets.size() > 255) ? 255 : m_dets.size();
            m_last = cnt;
            good   = (cnt >= LO) && (cnt <= HI);
            dead   = (cnt == 0);
            if (m_state == 2) begin
              if (dead) set = 1;
              m_good = good ? m_good + 1 : 0;
              if (m_good >= G) begin m_state = 3; m_good = 0; end
            end else if (!good) begin
              m_state = 4; set = 1;
            end
            m_wbeg = m_n + 1;
            m_dets.delete();
          end
        end
        default: begin m_state = 2; m_good = 0; m_wbeg = m_n + 1; m_dets.delete(); end
      endcase
    end
    if (set) m_fault = 1;
    else if (FAULT_CLR) m_fault = 0;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (m_ready) begin
      chk("mdl_state", STATE, m_state);
      chk("mdl_clk_ok", CLK_OK, int'(m_state == 3));
      chk("mdl_fab_reset_n", FAB_RESET_N, int'(m_state == 3));
      chk("mdl_fault", FAULT, m_fault);
      chk("mdl_last_count", LAST_COUNT, m_last);
    end
  end

  task automatic waitn(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_state(input int st, input int lim, input string nm);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge CLK);
      if (STATE == 3'(st)) found = 1;
    end
    chk(nm, found, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lf, per, len;
    RESET = 1'b1; ENABLE = 1'b0; FAULT_CLR = 1'b0;
    waitn(3);
    chk("rst_state", STATE, 0);
    chk("rst_clk_ok", CLK_OK, 0);
    chk("rst_fab_n", FAB_RESET_N, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_last", LAST_COUNT, 0);
    #1 RESET = 1'b0;

    // Nominal qualify
    @(negedge CLK); ENABLE = 1'b1;
    waitn(1);  chk("nom_warm_j1", STATE, 1);
    waitn(15); chk("nom_warm_j16", STATE, 1);
    waitn(1);  chk("nom_qual_j17", STATE, 2);
    waitn(79); chk("nom_ok_j96", CLK_OK, 0);
    waitn(1);  chk("nom_ok_j97", CLK_OK, 1);
    chk("nom_fab_j97", FAB_RESET_N, 1);
    chk("nom_run_j97", STATE, 3);
    chk("nom_last_rng", int'(LAST_COUNT >= 9 && LAST_COUNT <= 11), 1);
    chk("nom_fault", FAULT, 0);

    // Drift to period 5 while running
    mon_per = 5;
    wait_state(4, 200, "drift_reach_fault");
    chk("drift_clk_ok", CLK_OK, 0);
    chk("drift_fault", FAULT, 1);
    chk("drift_last_bad", int'(LAST_COUNT < 9), 1);
    waitn(1);  chk("drift_requal", STATE, 2);
    waitn(40); chk("drift_last8", LAST_COUNT, 8);
    chk("drift_fault_hold", FAULT, 1);
    mon_per = 4;
    wait_state(3, 250, "drift_recover_run");
    chk("drift_recover_ok", CLK_OK, 1);

    // ENABLE drop during RUN keeps FAULT and LAST_COUNT
    lf = LAST_COUNT;
    ENABLE = 1'b0;
    waitn(1);
    chk("endrop_state", STATE, 0);
    chk("endrop_clk_ok", CLK_OK, 0);
    chk("endrop_fault", FAULT, 1);
    chk("endrop_last", LAST_COUNT, lf);
    FAULT_CLR = 1'b1; waitn(1); FAULT_CLR = 1'b0;
    chk("clr_idle", FAULT, 0);

    // Dead clock and set/clear collision
    mon_per = 0;
    waitn(3); ENABLE = 1'b1;
    waitn(17); chk("dead_qual", STATE, 2);
    waitn(40);
    chk("dead_last", LAST_COUNT, 0);
    chk("dead_fault", FAULT, 1);
    chk("dead_state", STATE, 2);
    waitn(13); FAULT_CLR = 1'b1;
    waitn(1);  FAULT_CLR = 1'b0;
    chk("dead_clr", FAULT, 0);
    waitn(25); chk("dead_clr_hold", FAULT, 0);
    FAULT_CLR = 1'b1;
    waitn(1);  FAULT_CLR = 1'b0;
    chk("collide_fault", FAULT, 1);
    chk("collide_state", STATE, 2);
    chk("collide_clk_ok", CLK_OK, 0);

    // Good-run interruption: good, bad (period 3), good, good
    ENABLE = 1'b0; FAULT_CLR = 1'b1; mon_per = 4;
    waitn(1); FAULT_CLR = 1'b0;
    chk("intr_idle_fault", FAULT, 0);
    waitn(2); ENABLE = 1'b1;
    waitn(55); mon_per = 3;
    waitn(2);
    chk("intr_w1_last", LAST_COUNT, 10);
    chk("intr_w1_ok", CLK_OK, 0);
    waitn(38); mon_per = 4;
    waitn(2);
    chk("intr_w2_high", int'(LAST_COUNT > 11), 1);
    chk("intr_w2_nofault", FAULT, 0);
    chk("intr_w2_state", STATE, 2);
    waitn(40); chk("intr_w3_ok", CLK_OK, 0);
    waitn(39); chk("intr_j176_ok", CLK_OK, 0);
    waitn(1);  chk("intr_j177_ok", CLK_OK, 1);
    chk("intr_run", STATE, 3);

    // RESET mid-WARMUP
    ENABLE = 1'b0; waitn(2); ENABLE = 1'b1;
    waitn(8); chk("rstw_warm", STATE, 1);
    #1 RESET = 1'b1;
    waitn(1);
    chk("rstw_state", STATE, 0);
    chk("rstw_clk_ok", CLK_OK, 0);
    chk("rstw_fab_n", FAB_RESET_N, 0);
    chk("rstw_fault", FAULT, 0);
    chk("rstw_last", LAST_COUNT, 0);
    #1 RESET = 1'b0;
    waitn(1);  chk("rstw_j1", STATE, 1);
    waitn(15); chk("rstw_j16", STATE, 1);
    waitn(1);  chk("rstw_j17", STATE, 2);

    // Randomized traffic
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 9))
        5:       per = 5;
        6:       per = 3;
        7:       per = 0;
        8:       per = 6;
        default: per = 4;
      endcase
      mon_per = per;
      if ($urandom_range(0, 3) != 0) ENABLE = 1'b1;
      len = $urandom_range(30, 400);
      for (int c = 0; c < len; c++) begin
        @(negedge CLK);
        FAULT_CLR = ($urandom_range(0, 60) == 0);
        if ($urandom_range(0, 300) == 0) ENABLE = ~ENABLE;
      end
      if ($urandom_range(0, 15) == 0) begin
        #1 RESET = 1'b1;
        @(negedge CLK);
        #1 RESET = 1'b0;
      end
    end
    FAULT_CLR = 1'b0;
    waitn(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fabosc_clk_monitor.md
# fabosc_clk_monitor

Frequency monitor and reset sequencer for the fabric oscillator subsystem. It runs on the 50 MHz RC-oscillator fabric clock and counts edges of a slower monitored oscillator output (XTL or 1 MHz RC) over fixed windows. Fabric reset is released only after a warm-up period followed by consecutive in-range windows. While running, it re-asserts reset and raises a sticky fault if the monitored clock drifts out of range or stops.

## Interface
- WINDOW_CYCLES, 5000: CLK cycles per measurement window (100 µs at 50 MHz).
- COUNT_LO, 95: minimum MON_CLK rising edges in a good window.
- COUNT_HI, 105: maximum MON_CLK rising edges in a good window.
- GOOD_WINDOWS, 4: consecutive good windows required to qualify.
- WARMUP_CYCLES, 50000: CLK cycles of oscillator warm-up before measuring.
- CNT_W, 16: width of all counters and LAST_COUNT.
- CLK  in  1  fabric clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset (one clock; reset async active-high).
- MON_CLK  in  1  monitored oscillator; asynchronous to CLK, frequency ≤ CLK/4.
- ENABLE  in  1  level; 1 = run the sequence, 0 = return to IDLE.
- FAULT_CLR  in  1  single-cycle pulse; clears FAULT.
- CLK_OK  out  1  monitored clock qualified.
- FAB_RESET_N  out  1  active-low fabric reset; equals CLK_OK.
- FAULT  out  1  sticky fault flag.
- LAST_COUNT  out  CNT_W  edge count of the most recently completed window.
- STATE  out  3  IDLE=0, WARMUP=1, QUALIFY=2, RUN=3, FAULT=4.

## Operation
- Edge detection: two-flop synchronizer on MON_CLK, plus one history flop. A rising edge is sync2=1 and hist=0. Latency is 2–3 CLK from the MON_CLK edge.
- Edge counter: counts detected edges in the current window and saturates at 2^CNT_W−1.
- Window counter: runs 0..WINDOW_CYCLES−1 in QUALIFY and RUN.
  - On the last cycle, LAST_COUNT is loaded with the final count, including an edge detected in that cycle.
  - The edge counter then restarts at 0. An edge in cycle 0 of the next window counts toward that window.
- A window is good iff COUNT_LO ≤ count ≤ COUNT_HI. A window is dead iff count = 0.
- IDLE: counters cleared; CLK_OK=0. ENABLE=1 moves to WARMUP.
- WARMUP: counts WARMUP_CYCLES cycles, then moves to QUALIFY with the window and edge counters cleared.
- QUALIFY:
  - A good window increments the good-run counter; a bad window clears it.
  - When the good-run counter reaches GOOD_WINDOWS, the state moves to RUN.
  - A dead window sets FAULT but the state stays in QUALIFY.
- RUN: CLK_OK=1. Any bad window moves to FAULT and sets FAULT.
- FAULT: CLK_OK=0 for one cycle, then QUALIFY with the good-run counter and window counter cleared.
- ENABLE=0 in any state: IDLE on the next cycle, CLK_OK=0, and all counters cleared. FAULT and LAST_COUNT are retained.
- FAULT_CLR clears FAULT. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values: CLK_OK=0, FAB_RESET_N=0, FAULT=0, LAST_COUNT=0, STATE=0, all counters 0. The synchronizer flops also reset to 0.
- All outputs are registered.
- If ENABLE is first sampled high at edge k:
  - STATE=WARMUP from k+1.
  - STATE=QUALIFY from k+1+WARMUP_CYCLES.
  - If every window is good, CLK_OK=1 from k+1+WARMUP_CYCLES+GOOD_WINDOWS·WINDOW_CYCLES.
- LAST_COUNT, FAULT and state changes caused by window evaluation take effect on the clock after the last cycle of a window.
- A bad window in RUN drops CLK_OK/FAB_RESET_N on the same edge that updates LAST_COUNT.
- Because of synchronizer phase, measured counts may differ from nominal by ±1. Bounds must allow for this.
- RESET mid-sequence returns everything to reset values immediately. ENABLE, if still high, restarts from WARMUP.

## Test plan
Bench parameters: WINDOW_CYCLES=40, COUNT_LO=9, COUNT_HI=11, GOOD_WINDOWS=2, WARMUP_CYCLES=16, CNT_W=8.

- Nominal qualify: MON_CLK period 4 CLK, ENABLE high at edge 0 -> STATE 1 at cycle 1, STATE 2 at 17, CLK_OK=FAB_RESET_N=1 at 97, LAST_COUNT ∈ {9,10,11}, FAULT=0.
- Drift in RUN: after qualify, change MON_CLK period to 5 CLK -> LAST_COUNT=8, CLK_OK=0, STATE 4 for one cycle then 2, FAULT=1. Restore period 4 -> CLK_OK=1 again after 2 good windows.
- Dead clock: MON_CLK held at 0 -> STATE stays 2, LAST_COUNT=0, FAULT=1 after first window, CLK_OK never 1. FAULT_CLR pulse -> FAULT=0 until next window end.
- Set/clear collision: FAULT_CLR asserted on the cycle the dead window evaluates -> FAULT=1.
- Good-run interruption: windows good, bad (period 3, count ≈13), good -> no CLK_OK until a second consecutive good window. The QUALIFY bad window does not set FAULT.
- ENABLE drop and RESET: ENABLE=0 during RUN -> IDLE next cycle, CLK_OK=0, FAULT and LAST_COUNT unchanged. RESET pulse mid-WARMUP -> all outputs at reset values; on release, WARMUP restarts (STATE 2 reached 17 cycles later).
